conv_layer_kxk: RTL and testbench

Parametrised K×K single-channel convolution stage for the image-processing pipeline. It accepts a raster-ordered feature map with per-pixel h/v counts, keeps K-1 lines in an internal line buffer, and snapshots each complete window. The window is convolved against a run-time-loadable weight RAM, one kernel row per cycle. It emits a rescaled, saturated and optionally ReLU-clamped result with output-grid coordinates, supporting any kernel size, image size and stride.

---
 rtl/conv_pkg.sv | 40 ++++
 rtl/line_buffer_kxk.sv | 54 +++++
 rtl/conv_layer_kxk.sv | 137 +++++++++++++
 tb/tb_conv_layer_kxk.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the KxK convolution stage: engine states,
// derived widths and the result post-processing (rescale, saturate, ReLU).
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } conv_state_t;

    localparam int POST_W = 64;

    function automatic int acc_width(input int data_w, input int weight_w, input int k);
        return data_w + weight_w + $clog2(k * k);
    endfunction

    function automatic int addr_width(input int k);
        return (k * k > 1) ? $clog2(k * k) : 1;
    endfunction

    // Accumulator arrives sign-extended to POST_W; caller keeps the low data_w bits.
    function automatic logic signed [POST_W-1:0] post_process(
        input logic signed [POST_W-1:0] acc,
        input int                       frac_w,
        input int                       data_w,
        input logic                     relu
    );
        logic signed [POST_W-1:0] res;
        logic signed [POST_W-1:0] max_v;
        logic signed [POST_W-1:0] min_v;
        max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (data_w - 1));
        res   = acc >>> frac_w;
        if (res > max_v) res = max_v;
        if (res < min_v) res = min_v;
        if (relu && res < 0) res = '0;
        return res;
    endfunction

endpackage

// File: rtl/line_buffer_kxk.sv
// K-1 line memories plus a KxK tap array; presents the full window ending at
// the incoming pixel combinationally, in the same cycle the pixel arrives.
module line_buffer_kxk
    import conv_pkg::*;
#(
    parameter int K      = 9,
    parameter int IMG_W  = 32,
    parameter int DATA_W = 21
) (
    input  logic                          clk_in,
    input  logic                          data_valid_in,
    input  logic signed [DATA_W-1:0]      pixel_data_in,
    input  logic [$clog2(IMG_W)-1:0]      hcount_in,
    output logic [K*K*DATA_W-1:0]         taps_out
);

    // line_mem[0] holds the previous row, line_mem[K-2] the oldest one.
    logic signed [DATA_W-1:0] line_mem [K-1][IMG_W];
    logic signed [DATA_W-1:0] shift_q  [K][K-1];
    logic signed [DATA_W-1:0] column   [K];

    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            column[r] = line_mem[K-2-r][hcount_in];
        end
        column[K-1] = pixel_data_in;
    end

    always_ff @(posedge clk_in) begin
        if (data_valid_in) begin
            line_mem[0][hcount_in] <= pixel_data_in;
            for (int j = 1; j < K - 1; j++) begin
                line_mem[j][hcount_in] <= line_mem[j-1][hcount_in];
            end
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 2; c++) begin
                    shift_q[r][c] <= shift_q[r][c+1];
                end
                shift_q[r][K-2] <= column[r];
            end
        end
    end

    always_comb begin
        taps_out = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                taps_out[(r*K+c)*DATA_W +: DATA_W] = shift_q[r][c];
            end
            taps_out[(r*K+K-1)*DATA_W +: DATA_W] = column[r];
        end
    end

endmodule

// File: rtl/conv_layer_kxk.sv
// KxK single-channel convolution: snapshots each eligible window, multiplies
// one kernel row per cycle against the weight RAM, then rescales and saturates.
module conv_layer_kxk
    import conv_pkg::*;
#(
    parameter int K        = 9,
    parameter int IMG_W    = 32,
    parameter int IMG_H    = 32,
    parameter int DATA_W   = 21,
    parameter int WEIGHT_W = 18,
    parameter int FRAC_W   = 17,
    parameter int STRIDE   = 1,
    parameter int RELU     = 0
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              data_valid_in,
    input  logic signed [DATA_W-1:0]          pixel_data_in,
    input  logic [$clog2(IMG_W)-1:0]          hcount_in,
    input  logic [$clog2(IMG_H)-1:0]          vcount_in,
    input  logic                              weight_wr_in,
    input  logic [$clog2(K*K)-1:0]            weight_addr_in,
    input  logic signed [WEIGHT_W-1:0]        weight_data_in,
    output logic                              data_valid_out,
    output logic signed [DATA_W-1:0]          pixel_data_out,
    output logic [$clog2(IMG_W)-1:0]          hcount_out,
    output logic [$clog2(IMG_H)-1:0]          vcount_out,
    output logic                              busy_out,
    output logic                              overrun_out
);

    localparam int HCW    = $clog2(IMG_W);
    localparam int VCW    = $clog2(IMG_H);
    localparam int ACC_W  = acc_width(DATA_W, WEIGHT_W, K);
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int RW     = $clog2(K);
    localparam logic [HCW-1:0] K1_H = HCW'(K - 1);
    localparam logic [VCW-1:0] K1_V = VCW'(K - 1);

    logic [K*K*DATA_W-1:0]      taps;
    logic signed [DATA_W-1:0]   snap_q   [K*K];
    logic signed [WEIGHT_W-1:0] weight_q [K*K];
    logic [HCW-1:0]             org_h, coord_h_q;
    logic [VCW-1:0]             org_v, coord_v_q;
    logic                       trigger, eligible, accept;
    conv_state_t                state_q, state_d;
    logic [RW-1:0]              row_q;
    logic signed [ACC_W-1:0]    acc_q, row_sum;
    logic signed [DATA_W-1:0]   post_data;

    line_buffer_kxk #(.K(K), .IMG_W(IMG_W), .DATA_W(DATA_W)) u_line_buffer (
        .clk_in        (clk_in),
        .data_valid_in (data_valid_in),
        .pixel_data_in (pixel_data_in),
        .hcount_in     (hcount_in),
        .taps_out      (taps)
    );

    assign org_h    = hcount_in - K1_H;
    assign org_v    = vcount_in - K1_V;
    assign trigger  = data_valid_in && (hcount_in >= K1_H) && (vcount_in >= K1_V);
    assign eligible = trigger && (org_h % HCW'(STRIDE) == '0) && (org_v % VCW'(STRIDE) == '0);
    assign accept   = eligible && (state_q == IDLE);
    assign busy_out = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (eligible) state_d = MAC;
            MAC:     if (row_q == RW'(K - 1)) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One kernel row of products, selected by the MAC row counter.
    always_comb begin
        row_sum = '0;
        for (int c = 0; c < K; c++) begin
            row_sum += ACC_W'(PROD_W'(snap_q[int'(row_q)*K + c]) * PROD_W'(weight_q[int'(row_q)*K + c]));
        end
    end

    assign post_data = DATA_W'(post_process(POST_W'(acc_q), FRAC_W, DATA_W, RELU != 0));

    // Snapshot and coordinate registers need no reset: only read after a capture.
    always_ff @(posedge clk_in) begin
        if (accept) begin
            for (int i = 0; i < K * K; i++) begin
                snap_q[i] <= taps[i*DATA_W +: DATA_W];
            end
            coord_h_q <= org_h / HCW'(STRIDE);
            coord_v_q <= org_v / VCW'(STRIDE);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            row_q          <= '0;
            acc_q          <= '0;
            overrun_out    <= 1'b0;
            data_valid_out <= 1'b0;
            pixel_data_out <= '0;
            hcount_out     <= '0;
            vcount_out     <= '0;
            for (int i = 0; i < K * K; i++) begin
                weight_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            data_valid_out <= 1'b0;
            if (eligible && state_q != IDLE) overrun_out <= 1'b1;
            if (weight_wr_in && state_q == IDLE && int'(weight_addr_in) < K * K) begin
                weight_q[weight_addr_in] <= weight_data_in;
            end
            case (state_q)
                IDLE: if (eligible) begin
                    acc_q <= '0;
                    row_q <= '0;
                end
                MAC: begin
                    acc_q <= acc_q + row_sum;
                    row_q <= row_q + RW'(1);
                end
                OUT: begin
                    data_valid_out <= 1'b1;
                    pixel_data_out <= post_data;
                    hcount_out     <= coord_h_q;
                    vcount_out     <= coord_v_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_kxk.sv
// Bench for conv_layer_kxk: two instances (stride 1 / stride 2 with ReLU) fed
// the same pixels, checked against a frame-level convolution model.
`timescale 1ns/1ps
module tb_conv_layer_kxk;

    localparam int K        = 3;
    localparam int IMG_W    = 8;
    localparam int IMG_H    = 8;
    localparam int DATA_W   = 21;
    localparam int WEIGHT_W = 19;
    localparam int FRAC_W   = 17;
    localparam int HCW      = 3;
    localparam int VCW      = 3;
    localparam int AW       = 4;
    localparam longint ONE  = 64'sd131072;
    localparam longint PMAX = 64'sd1048575;
    localparam longint PMIN = -64'sd1048576;
    localparam int SENT     = -99999999;

    typedef struct packed {
        logic [31:0]       cyc;
        logic [7:0]        y;
        logic [7:0]        x;
        logic [DATA_W-1:0] val;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                       data_valid_in = 1'b0;
    logic signed [DATA_W-1:0]   pixel_data_in = '0;
    logic [HCW-1:0]             hcount_in = '0;
    logic [VCW-1:0]             vcount_in = '0;
    logic                       weight_wr_in = 1'b0;
    logic [AW-1:0]              weight_addr_in = '0;
    logic signed [WEIGHT_W-1:0] weight_data_in = '0;

    logic dv_a, busy_a, ovr_a, dv_b, busy_b, ovr_b;
    logic signed [DATA_W-1:0] pd_a, pd_b;
    logic [HCW-1:0] ho_a, ho_b;
    logic [VCW-1:0] vo_a, vo_b;

    conv_layer_kxk #(.K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W),
                     .FRAC_W(FRAC_W), .STRIDE(1), .RELU(0)) u_dut_a (
        .clk_in(clk), .rst_in(rst), .data_valid_in(data_valid_in), .pixel_data_in(pixel_data_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .weight_wr_in(weight_wr_in),
        .weight_addr_in(weight_addr_in), .weight_data_in(weight_data_in),
        .data_valid_out(dv_a), .pixel_data_out(pd_a), .hcount_out(ho_a), .vcount_out(vo_a),
        .busy_out(busy_a), .overrun_out(ovr_a)
    );

    conv_layer_kxk #(.K(K), .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(DATA_W), .WEIGHT_W(WEIGHT_W),
                     .FRAC_W(FRAC_W), .STRIDE(2), .RELU(1)) u_dut_b (
        .clk_in(clk), .rst_in(rst), .data_valid_in(data_valid_in), .pixel_data_in(pixel_data_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in), .weight_wr_in(weight_wr_in),
        .weight_addr_in(weight_addr_in), .weight_data_in(weight_data_in),
        .data_valid_out(dv_b), .pixel_data_out(pd_b), .hcount_out(ho_b), .vcount_out(vo_b),
        .busy_out(busy_b), .overrun_out(ovr_b)
    );

    // ---------------- model state ----------------
    longint pix [IMG_H][IMG_W];
    longint w   [2][K*K];
    int     last_acc [2];
    int     ov_edge  [2];
    int     cap [2][IMG_H][IMG_W];
    int     n_out [2];
    logic signed [DATA_W-1:0] last_val [2];
    bit     have_last [2];
    exp_t   exp_a[$];
    exp_t   exp_b[$];
    int     n_vec = 0;
    int     n_bad = 0;

    function automatic int stride_of(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic longint conv_model(input int d, input int oh, input int ov);
        longint acc;
        acc = 0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                acc += pix[ov+r][oh+c] * w[d][r*K+c];
        acc = acc >>> FRAC_W;
        if (acc > PMAX) acc = PMAX;
        if (acc < PMIN) acc = PMIN;
        if (d == 1 && acc < 0) acc = 0;
        return acc;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? exp_a.size() : exp_b.size();
    endfunction

    function automatic exp_t qfront(input int d);
        return (d == 0) ? exp_a[0] : exp_b[0];
    endfunction

    function automatic void qpop(input int d);
        if (d == 0) void'(exp_a.pop_front());
        else void'(exp_b.pop_front());
    endfunction

    function automatic void qpush(input int d, input exp_t e);
        if (d == 0) exp_a.push_back(e);
        else exp_b.push_back(e);
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input longint act, input longint req);
        n_vec++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic cmp_dut(input int d, input logic dv, input logic signed [DATA_W-1:0] pd,
                           input logic [HCW-1:0] ho, input logic [VCW-1:0] vo,
                           input logic busy, input logic ovr);
        exp_t e;
        while (qsize(d) > 0 && int'(qfront(d).cyc) < cyc) begin
            e = qfront(d);
            qpop(d);
            n_vec++;
            n_bad++;
            $display("FAIL dut%0d result_missing: no strobe, required %0d at (%0d,%0d) cycle %0d",
                     d, $signed(e.val), e.x, e.y, e.cyc);
        end
        if (dv) begin
            n_vec++;
            if (qsize(d) == 0) begin
                n_bad++;
                $display("FAIL dut%0d unexpected_strobe: got %0d at (%0d,%0d) cycle %0d, required none",
                         d, pd, ho, vo, cyc);
            end else begin
                e = qfront(d);
                qpop(d);
                if (pd !== $signed(e.val) || int'(ho) != int'(e.x) || int'(vo) != int'(e.y) ||
                    int'(e.cyc) != cyc) begin
                    n_bad++;
                    $display("FAIL dut%0d result: got %0d at (%0d,%0d) cycle %0d, required %0d at (%0d,%0d) cycle %0d",
                             d, pd, ho, vo, cyc, $signed(e.val), e.x, e.y, e.cyc);
                end
            end
            cap[d][vo][ho] = int'(pd);
            n_out[d]++;
            last_val[d]  = pd;
            have_last[d] = 1'b1;
        end else if (have_last[d]) begin
            check($sformatf("dut%0d hold", d), pd, last_val[d]);
        end
        check($sformatf("dut%0d busy", d), busy, (cyc >= last_acc[d] && cyc <= last_acc[d] + K) ? 1 : 0);
        check($sformatf("dut%0d overrun", d), ovr, (cyc >= ov_edge[d]) ? 1 : 0);
    endtask

    always @(negedge clk) begin
        cmp_dut(0, dv_a, pd_a, ho_a, vo_a, busy_a, ovr_a);
        cmp_dut(1, dv_b, pd_b, ho_b, vo_b, busy_b, ovr_b);
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic model_reset();
        exp_a.delete();
        exp_b.delete();
        for (int d = 0; d < 2; d++) begin
            last_acc[d]  = -100;
            ov_edge[d]   = 1 << 30;
            have_last[d] = 1'b0;
            for (int i = 0; i < K * K; i++) w[d][i] = 0;
        end
    endtask

    task automatic feed_pixel(input int h, input int v, input longint val);
        int   e_edge, oh, ov, s;
        exp_t e;
        e_edge = cyc + 1;
        pix[v][h] = val;
        for (int d = 0; d < 2; d++) begin
            if (h >= K - 1 && v >= K - 1) begin
                oh = h - K + 1;
                ov = v - K + 1;
                s  = stride_of(d);
                if (oh % s == 0 && ov % s == 0) begin
                    if (e_edge >= last_acc[d] + K + 2) begin
                        last_acc[d] = e_edge;
                        e.cyc = 32'(e_edge + K + 1);
                        e.x   = 8'(oh / s);
                        e.y   = 8'(ov / s);
                        e.val = DATA_W'(conv_model(d, oh, ov));
                        qpush(d, e);
                    end else if (ov_edge[d] > e_edge) begin
                        ov_edge[d] = e_edge;
                    end
                end
            end
        end
        data_valid_in = 1'b1;
        pixel_data_in = DATA_W'(val);
        hcount_in     = HCW'(h);
        vcount_in     = VCW'(v);
        tick();
        data_valid_in = 1'b0;
    endtask

    task automatic write_weight(input int addr, input longint val);
        int e_edge;
        e_edge = cyc + 1;
        for (int d = 0; d < 2; d++)
            if (!(e_edge >= last_acc[d] + 1 && e_edge <= last_acc[d] + K + 1)) w[d][addr] = val;
        weight_wr_in   = 1'b1;
        weight_addr_in = AW'(addr);
        weight_data_in = WEIGHT_W'(val);
        tick();
        weight_wr_in = 1'b0;
    endtask

    task automatic load_weights(input int kind);
        for (int i = 0; i < K * K; i++) begin
            case (kind)
                0:       write_weight(i, (i == 4) ? ONE : 0);
                1:       write_weight(i, ONE);
                default: write_weight(i, ONE - 1);
            endcase
        end
    endtask

    // kind 0: pixel = 8v+h, otherwise constant cval
    task automatic run_frame(input int gap, input int kind, input longint cval);
        for (int d = 0; d < 2; d++) begin
            n_out[d] = 0;
            for (int y = 0; y < IMG_H; y++)
                for (int x = 0; x < IMG_W; x++) cap[d][y][x] = SENT;
        end
        for (int v = 0; v < IMG_H; v++) begin
            for (int h = 0; h < IMG_W; h++) begin
                feed_pixel(h, v, (kind == 0) ? longint'(8 * v + h) : cval);
                idle(gap - 1);
            end
        end
        idle(K + 4);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        model_reset();
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        tick();
        check("reset dv_a", dv_a, 0);
        check("reset pd_a", pd_a, 0);
        check("reset busy_a", busy_a, 0);
        check("reset ovr_a", ovr_a, 0);

        // identity kernel
        load_weights(0);
        run_frame(5, 0, 0);
        check("identity count a", n_out[0], 36);
        check("identity count b", n_out[1], 9);
        check("identity a(0,0)", cap[0][0][0], 9);
        check("identity a(5,5)", cap[0][5][5], 54);
        check("identity a(3,2)", cap[0][2][3], 28);
        check("stride b(2,1)", cap[1][1][2], 29);
        check("stride b(2,2)", cap[1][2][2], 45);

        // box kernel
        load_weights(1);
        run_frame(5, 1, 1);
        check("box a(4,3)", cap[0][3][4], 9);
        check("box b(2,2)", cap[1][2][2], 9);
        check("box count a", n_out[0], 36);

        // saturation, positive then negative (b clamps via ReLU)
        load_weights(2);
        run_frame(5, 1, PMAX);
        check("sat pos a", cap[0][0][0], PMAX);
        check("sat pos b", cap[1][1][1], PMAX);
        run_frame(5, 1, -PMAX);
        check("sat neg a", cap[0][4][4], PMIN);
        check("relu neg b", cap[1][0][0], 0);

        // overrun: one pixel per cycle
        load_weights(0);
        run_frame(1, 0, 0);
        check("overrun flag a", ovr_a, 1);
        check("overrun a(0,0)", cap[0][0][0], 9);
        check("overrun a(5,0)", cap[0][0][5], 14);

        // weight write while busy, latency
        for (int d = 0; d < 2; d++) for (int x = 0; x < IMG_W; x++) cap[d][0][x] = SENT;
        for (int v = 0; v < 2; v++)
            for (int h = 0; h < IMG_W; h++) begin
                feed_pixel(h, v, longint'(8 * v + h));
                idle(4);
            end
        feed_pixel(0, 2, 16);
        idle(4);
        feed_pixel(1, 2, 17);
        idle(4);
        feed_pixel(2, 2, 18);
        write_weight(4, 0);
        n = 1;
        while (!dv_a && n < 20) begin
            tick();
            n++;
        end
        check("latency", n, K + 1);
        idle(3);
        check("busy write ignored a(0,0)", cap[0][0][0], 9);
        write_weight(4, 0);
        write_weight(0, ONE);
        feed_pixel(3, 2, 19);
        idle(K + 3);
        check("new weights a(1,0)", cap[0][0][1], 1);

        // reset mid-MAC
        feed_pixel(4, 2, 20);
        idle(2);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst dv_a", dv_a, 0);
        check("rst pd_a", pd_a, 0);
        check("rst ho_a", ho_a, 0);
        check("rst busy_a", busy_a, 0);
        check("rst ovr_a", ovr_a, 0);
        check("rst busy_b", busy_b, 0);
        tick();
        rst = 1'b0;
        idle(12);

        // recovery frame
        load_weights(0);
        run_frame(5, 0, 0);
        check("recovery a(5,5)", cap[0][5][5], 54);
        check("recovery count a", n_out[0], 36);
        idle(5);
        check("queue a drained", qsize(0), 0);
        check("queue b drained", qsize(1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
